cxapbasyncbridge_fifo_wr_ctrl: RTL
==================================

CXAPBASYNCBRIDGE_FIFO_WR_CTRL -- requirements
Module: cxapbasyncbridge_fifo_wr_ctrl

Interface
REQ-001 Parameter: ADDR_WIDTH, default 2, FIFO depth = 2**ADDR_WIDTH entries; pointers are ADDR_WIDTH+1 bits (PW).
REQ-002 clk  input  1  single write-domain clock; all state on rising edge.
REQ-003 resetn  input  1  asynchronous active-low reset.
REQ-004 ctrl_en  input  1  level; 1 = accept pushes, 0 = request drain-and-stop.
REQ-005 push_valid  input  1  requester has an entry to write.
REQ-006 push_ready  output  1  controller can accept; a push transfers when push_valid & push_ready.
REQ-007 rd_ptr_gry_sync  input  PW  read pointer, Gray-coded, already synchronised into clk domain.
REQ-008 wr_en  output  1  write strobe to storage, combinational = accepted push.
REQ-009 wr_addr  output  ADDR_WIDTH  storage address = wr_ptr_bin[ADDR_WIDTH-1:0].
REQ-010 wr_ptr_gry  output  PW  Gray write pointer, registered, feeds the CDC launch register data input.
REQ-011 launch_en  output  1  enable for the CDC launch register, registered.
REQ-012 level  output  PW  registered occupancy 0..2**ADDR_WIDTH.
REQ-013 full  output  1  registered; empty  output  1  registered.
REQ-014 idle  output  1  registered; 1 when state STOPPED.

Function
REQ-015 Internal wr_ptr_bin (PW bits) increments by 1 modulo 2**PW per accepted push; wr_ptr_gry = wr_ptr_bin ^ (wr_ptr_bin >> 1), registered on the same edge.
REQ-016 Accepted push in cycle N: wr_en, wr_addr valid in N; wr_ptr_gry shows new value in N+1; launch_en = 1 in N+1 only (back-to-back pushes keep launch_en high).
REQ-017 wr_ptr_gry SHALL change by exactly one bit per update; never updates without a push.
REQ-018 full = 1 when wr_ptr_gry == {~rd_ptr_gry_sync[PW-1:PW-2], rd_ptr_gry_sync[PW-3:0]} (for ADDR_WIDTH=1: top two bits = entire pointer), evaluated on next-state pointer, registered.
REQ-019 empty = 1 when next wr_ptr_gry == rd_ptr_gry_sync, registered.
REQ-020 level = wr_ptr_bin_next - gray2bin(rd_ptr_gry_sync), modulo 2**PW, registered.
REQ-021 push_ready = (state == RUN) & ~full.
REQ-022 FSM states: STOPPED, RUN, DRAIN.
REQ-023 STOPPED -> RUN when ctrl_en = 1; RUN -> DRAIN when ctrl_en = 0; DRAIN -> STOPPED when empty = 1; DRAIN -> RUN when ctrl_en = 1 (re-enable wins over empty in same cycle).
REQ-024 No push accepted in STOPPED or DRAIN; a push_valid held across ctrl_en falling is not accepted after the falling cycle.
REQ-025 Push while full: push_ready = 0, no pointer change, no wr_en.
REQ-026 Pointer wrap: 2**PW-1 -> 0 SHALL be a single-bit Gray change and full/level remain correct.
REQ-027 rd_ptr_gry_sync change and push in same cycle: both reflected in full/empty/level next cycle.

Reset
REQ-028 resetn low: state STOPPED, wr_ptr_bin = 0, wr_ptr_gry = 0, launch_en = 0, level = 0, full = 0, empty = 1, idle = 1, push_ready = 0.
REQ-029 Reset mid-burst SHALL abort immediately; no wr_en while resetn low.
REQ-030 Controller resumes only via STOPPED -> RUN after resetn release.

Configuration
REQ-031 Macro CXAPBASYNCBRIDGE_OVERFLOW_ERR_EN defined: extra output ovf_err (1 bit), sticky, set on push_valid & full & state RUN, cleared only by reset.
REQ-032 Macro undefined: ovf_err port absent; all other behaviour identical.

Verification
REQ-033 Reset, ctrl_en=1, 4 pushes with rd_ptr_gry_sync=0 (ADDR_WIDTH=2) -> wr_ptr_gry 1,3,2,6; full=1 after 4th, level=4, push_ready=0.
REQ-034 Full, push_valid=1 held 3 cycles -> no wr_en, wr_ptr_gry stays 6; with macro, ovf_err=1 and stays 1.
REQ-035 Stream 40 pushes with read pointer tracking 2 behind -> every wr_ptr_gry update differs by one bit incl. wrap 7->0; launch_en exactly one cycle after each push.
REQ-036 ctrl_en=0 with level=3 -> DRAIN, push_ready=0; rd_ptr_gry_sync advanced to equal wr_ptr_gry -> idle=1 next cycle.
REQ-037 resetn asserted during back-to-back pushes -> all outputs at REQ-028 values asynchronously; ctrl_en=1 after release -> first push at wr_addr 0.

Source files
------------

// File: rtl/cxapbasyncbridge_fifo_wr_ctrl.sv
// Write-side pointer/flag controller for the APB async bridge FIFO: Gray write pointer launch plus run/drain/stop FSM.
// Optional sticky overflow flag ovf_err is built when CXAPBASYNCBRIDGE_OVERFLOW_ERR_EN is defined.
module cxapbasyncbridge_fifo_wr_ctrl #(
  parameter int ADDR_WIDTH = 2,
  localparam int PW = ADDR_WIDTH + 1
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic                  ctrl_en,
  input  logic                  push_valid,
  output logic                  push_ready,
  input  logic [PW-1:0]         rd_ptr_gry_sync,
  output logic                  wr_en,
  output logic [ADDR_WIDTH-1:0] wr_addr,
  output logic [PW-1:0]         wr_ptr_gry,
  output logic                  launch_en,
  output logic [PW-1:0]         level,
  output logic                  full,
  output logic                  empty,
  output logic                  idle
`ifdef CXAPBASYNCBRIDGE_OVERFLOW_ERR_EN
  ,
  output logic                  ovf_err
`endif
);

  typedef enum logic [1:0] {
    STOPPED = 2'd0,
    RUN     = 2'd1,
    DRAIN   = 2'd2
  } state_t;

  // Full when the pointers differ only in their top two Gray bits.
  localparam logic [PW-1:0] FULL_MASK = PW'(3) << (PW - 2);

  state_t          state;
  logic [PW-1:0]   wr_ptr_bin;
  logic [PW-1:0]   wr_ptr_bin_nxt;
  logic [PW-1:0]   wr_ptr_gry_nxt;
  logic [PW-1:0]   rd_ptr_bin;
  logic            full_nxt;
  logic            empty_nxt;

  function automatic logic [PW-1:0] gray2bin(input logic [PW-1:0] g);
    logic [PW-1:0] b;
    b[PW-1] = g[PW-1];
    for (int i = PW - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

  assign push_ready     = (state == RUN) && !full;
  assign wr_en          = push_valid && push_ready;
  assign wr_addr        = wr_ptr_bin[ADDR_WIDTH-1:0];
  assign wr_ptr_bin_nxt = wr_ptr_bin + PW'(wr_en);
  assign wr_ptr_gry_nxt = wr_ptr_bin_nxt ^ (wr_ptr_bin_nxt >> 1);
  assign rd_ptr_bin     = gray2bin(rd_ptr_gry_sync);
  assign full_nxt       = (wr_ptr_gry_nxt == (rd_ptr_gry_sync ^ FULL_MASK));
  assign empty_nxt      = (wr_ptr_gry_nxt == rd_ptr_gry_sync);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wr_ptr_bin <= '0;
      wr_ptr_gry <= '0;
      launch_en  <= 1'b0;
      level      <= '0;
      full       <= 1'b0;
      empty      <= 1'b1;
    end else begin
      wr_ptr_bin <= wr_ptr_bin_nxt;
      wr_ptr_gry <= wr_ptr_gry_nxt;
      launch_en  <= wr_en;
      level      <= wr_ptr_bin_nxt - rd_ptr_bin;
      full       <= full_nxt;
      empty      <= empty_nxt;
    end
  end

  // Drain exits on the freshly computed empty so idle follows the read pointer by one cycle;
  // re-enable takes priority over the drain completing.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state <= STOPPED;
      idle  <= 1'b1;
    end else begin
      case (state)
        STOPPED: begin
          if (ctrl_en) begin
            state <= RUN;
            idle  <= 1'b0;
          end
        end
        RUN: begin
          if (!ctrl_en) state <= DRAIN;
        end
        DRAIN: begin
          if (ctrl_en) begin
            state <= RUN;
          end else if (empty_nxt) begin
            state <= STOPPED;
            idle  <= 1'b1;
          end
        end
        default: begin
          state <= STOPPED;
          idle  <= 1'b1;
        end
      endcase
    end
  end

`ifdef CXAPBASYNCBRIDGE_OVERFLOW_ERR_EN
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      ovf_err <= 1'b0;
    end else if (push_valid && full && (state == RUN)) begin
      ovf_err <= 1'b1;
    end
  end
`endif

endmodule
